// File: rtl/inst_prefetch_queue.sv
// inst_prefetch_queue
//   Prefetches instruction words from a synchronous ROM into a small FIFO so
//   the decoder/step controller always finds the next instruction ready.
//   Branch/jump redirects and restarts flush both the queue and any read
//   already in flight.
//
// Ports
//   clk            system clock, all state on posedge
//   init_n         asynchronous active-low reset
//   start          pulse: load PC from start_addr, flush, enter RUN
//   start_addr     program start address
//   redirect       pulse (RUN only): flush, restart at redirect_addr
//   redirect_addr  branch/jump target
//   halt           pulse: stop issuing fetches until next start
//   imem_rd_en     ROM read strobe (registered)
//   imem_addr      ROM address (registered)
//   imem_data      ROM data, valid one cycle after rd_en/addr
//   inst_out       head-of-queue instruction
//   inst_pc        address of inst_out
//   inst_valid     queue non-empty
//   inst_ready     consumer accepts head this cycle
//   count          queue occupancy 0..DEPTH
//
// States
//   state  | meaning
//   IDLE   | after reset, no fetching until start
//   RUN    | issuing reads while credit is available
//   STOP   | halted: no new reads, queue drains, waits for start

module inst_prefetch_queue #(
  parameter int                ADDR_W   = 9,
  parameter int                INST_W   = 9,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              init_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              halt,
  output logic              imem_rd_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_data,
  output logic [INST_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [2:0]        count
);

  localparam int         PTR_W   = $clog2(DEPTH);
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_imem_addr;
  logic              r_imem_rd_en;
  logic              r_inflight;
  logic [INST_W-1:0] r_fifo_inst [DEPTH];
  logic [ADDR_W-1:0] r_fifo_pc   [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [2:0]        r_count;

  logic              w_run;
  logic              w_flush;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_target;
  logic [3:0]        w_credit_used;

  assign w_run    = (r_state == S_RUN);
  assign w_flush  = start | (w_run & redirect);
  assign w_target = start ? start_addr : redirect_addr;

  // Entries queued plus the one read in flight must leave room, so a
  // returning word always has a slot and the FIFO can never overflow.
  assign w_credit_used = {1'b0, r_count} + {3'b000, r_inflight};
  assign w_issue = w_run & ~start & ~redirect & ~halt & (w_credit_used < DEPTH_C);

  // A flush drops both the returning word and any pop on the same edge.
  assign w_push = r_inflight & ~w_flush;
  assign w_pop  = (r_count != 3'd0) & inst_ready & ~w_flush;

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (start)              w_state_nxt = S_RUN;
    else if (w_run && halt) w_state_nxt = S_STOP;
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      r_pc         <= RESET_PC;
      r_imem_addr  <= RESET_PC;
      r_imem_rd_en <= 1'b0;
      r_inflight   <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= 3'd0;
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo_inst[i] <= '0;
        r_fifo_pc[i]   <= '0;
      end
    end else begin
      r_imem_rd_en <= w_issue;
      r_inflight   <= w_issue;
      if (w_issue) r_imem_addr <= r_pc;

      if (w_flush)      r_pc <= w_target;
      else if (w_issue) r_pc <= r_pc + ADDR_W'(1);

      if (w_flush) begin
        // Head pointer is kept; the stale head is don't-care while empty.
        r_wr_ptr <= r_rd_ptr;
        r_count  <= 3'd0;
      end else begin
        if (w_push) begin
          r_fifo_inst[r_wr_ptr] <= imem_data;
          r_fifo_pc[r_wr_ptr]   <= r_imem_addr;
          r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};
      end
    end
  end

  assign imem_rd_en = r_imem_rd_en;
  assign imem_addr  = r_imem_addr;
  assign inst_out   = r_fifo_inst[r_rd_ptr];
  assign inst_pc    = r_fifo_pc[r_rd_ptr];
  assign inst_valid = (r_count != 3'd0);
  assign count      = r_count;

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Bench for inst_prefetch_queue. ROM contents are mem[a] = a, so every
// expected instruction word equals its address.

module tb_inst_prefetch_queue;

  logic       clk = 1'b0;
  logic       init_n = 1'b0;
  logic       start = 1'b0;
  logic       redirect = 1'b0;
  logic       halt = 1'b0;
  logic       inst_ready = 1'b0;
  logic [8:0] start_addr = 9'h000;
  logic [8:0] redirect_addr = 9'h000;
  logic       imem_rd_en;
  logic [8:0] imem_addr;
  logic [8:0] imem_data;
  logic [8:0] inst_out;
  logic [8:0] inst_pc;
  logic       inst_valid;
  logic [2:0] count;

  int n_tests = 0;
  int n_fail  = 0;
  int rd_cnt  = 0;

  inst_prefetch_queue dut (
    .clk           (clk),
    .init_n        (init_n),
    .start         (start),
    .start_addr    (start_addr),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .halt          (halt),
    .imem_rd_en    (imem_rd_en),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .inst_out      (inst_out),
    .inst_pc       (inst_pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .count         (count)
  );

  // ROM: address is registered by the DUT, data presented during the next cycle.
  assign imem_data = imem_addr;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Behavioural model: a queue of pending addresses plus the outstanding read.
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_STOP = 2;

  int         m_state;
  logic [8:0] m_pc;
  logic [8:0] m_addr;
  bit         m_rd_en;
  bit         m_inflight;
  logic [8:0] m_q[$];
  bit         m_flush;
  bit         m_issue;
  bit         m_pop;

  always @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      m_state    = M_IDLE;
      m_pc       = 9'h000;
      m_addr     = 9'h000;
      m_rd_en    = 1'b0;
      m_inflight = 1'b0;
      m_q.delete();
    end else begin
      m_flush = start || (m_state == M_RUN && redirect);
      m_issue = (m_state == M_RUN) && !start && !redirect && !halt &&
                (m_q.size() + int'(m_inflight) < 4);
      m_pop   = inst_ready && (m_q.size() > 0);
      if (m_flush) m_q.delete();
      else begin
        if (m_pop) void'(m_q.pop_front());
        if (m_inflight) m_q.push_back(m_addr);
      end
      m_inflight = m_issue;
      m_rd_en    = m_issue;
      if (m_issue) begin
        m_addr = m_pc;
        m_pc   = m_pc + 9'd1;
      end
      if (start) m_pc = start_addr;
      else if (m_state == M_RUN && redirect) m_pc = redirect_addr;
      if (start) m_state = M_RUN;
      else if (m_state == M_RUN && halt) m_state = M_STOP;
    end
  end

  always @(negedge clk) begin
    if (init_n) begin
      chk("mdl_valid", int'(inst_valid), int'(m_q.size() > 0));
      chk("mdl_count", int'(count), m_q.size());
      chk("mdl_rd_en", int'(imem_rd_en), int'(m_rd_en));
      if (m_rd_en) chk("mdl_addr", int'(imem_addr), int'(m_addr));
      if (m_q.size() > 0) begin
        chk("mdl_inst_out", int'(inst_out), int'(m_q[0]));
        chk("mdl_inst_pc", int'(inst_pc), int'(m_q[0]));
      end
    end
  end

  always @(negedge clk) begin
    if (init_n && imem_rd_en) rd_cnt++;
  end

  initial begin
    int exp_v;
    #12;
    chk("rst_valid", int'(inst_valid), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_rd_en", int'(imem_rd_en), 0);
    chk("rst_addr", int'(imem_addr), 0);
    chk("rst_inst_out", int'(inst_out), 0);
    chk("rst_inst_pc", int'(inst_pc), 0);
    @(negedge clk);
    init_n = 1'b1;
    repeat (3) cyc();
    chk("idle_rd_en", int'(imem_rd_en), 0);
    chk("idle_valid", int'(inst_valid), 0);

    // Fill
    start_addr = 9'h010; start = 1'b1; rd_cnt = 0;
    cyc(); start = 1'b0;
    chk("t1_k_valid", int'(inst_valid), 0);
    chk("t1_k_rd_en", int'(imem_rd_en), 0);
    cyc();
    chk("t1_k1_rd_en", int'(imem_rd_en), 1);
    chk("t1_k1_addr", int'(imem_addr), 'h010);
    cyc();
    chk("t1_k2_valid", int'(inst_valid), 1);
    chk("t1_k2_inst", int'(inst_out), 'h010);
    chk("t1_k2_count", int'(count), 1);
    repeat (5) cyc();
    chk("t1_full_count", int'(count), 4);
    chk("t1_reads", rd_cnt, 4);
    chk("t1_full_rd_en", int'(imem_rd_en), 0);

    // Stream
    inst_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      chk("t2_valid", int'(inst_valid), 1);
      chk("t2_inst", int'(inst_out), 'h010 + i);
      cyc();
    end
    chk("t2_count", int'(count), 2);

    // Redirect with queue of 3 plus a read in flight
    inst_ready = 1'b0;
    cyc();
    chk("t3_pre_count", int'(count), 3);
    chk("t3_pre_rd_en", int'(imem_rd_en), 1);
    chk("t3_pre_addr", int'(imem_addr), 'h01F);
    redirect_addr = 9'h100; redirect = 1'b1;
    cyc(); redirect = 1'b0;
    chk("t3_flush_count", int'(count), 0);
    chk("t3_flush_valid", int'(inst_valid), 0);
    chk("t3_flush_rd_en", int'(imem_rd_en), 0);
    cyc();
    chk("t3_rd_en", int'(imem_rd_en), 1);
    chk("t3_addr", int'(imem_addr), 'h100);
    cyc();
    chk("t3_valid", int'(inst_valid), 1);
    chk("t3_inst", int'(inst_out), 'h100);
    chk("t3_pc", int'(inst_pc), 'h100);

    // Wrap
    start_addr = 9'h1FE; inst_ready = 1'b1; start = 1'b1;
    cyc(); start = 1'b0;
    cyc(); cyc();
    for (int i = 0; i < 4; i++) begin
      exp_v = ('h1FE + i) & 'h1FF;
      chk("t4_valid", int'(inst_valid), 1);
      chk("t4_inst", int'(inst_out), exp_v);
      chk("t4_pc", int'(inst_pc), exp_v);
      cyc();
    end

    // Halt
    inst_ready = 1'b0; start_addr = 9'h040; start = 1'b1;
    cyc(); start = 1'b0;
    cyc(); cyc(); cyc();
    chk("t5_pre_count", int'(count), 2);
    halt = 1'b1;
    cyc(); halt = 1'b0;
    chk("t5_captured", int'(count), 3);
    chk("t5_rd_en", int'(imem_rd_en), 0);
    rd_cnt = 0; inst_ready = 1'b1;
    cyc();
    redirect_addr = 9'h080; redirect = 1'b1;
    cyc(); redirect = 1'b0;
    repeat (4) cyc();
    chk("t5_drained", int'(count), 0);
    chk("t5_valid", int'(inst_valid), 0);
    chk("t5_no_reads", rd_cnt, 0);
    start_addr = 9'h020; start = 1'b1;
    cyc(); start = 1'b0;
    cyc(); cyc();
    chk("t5_resume_valid", int'(inst_valid), 1);
    chk("t5_resume_inst", int'(inst_out), 'h020);

    // Async reset mid-stream
    repeat (4) cyc();
    #2 init_n = 1'b0;
    #1;
    chk("t6_valid", int'(inst_valid), 0);
    chk("t6_rd_en", int'(imem_rd_en), 0);
    chk("t6_count", int'(count), 0);
    @(negedge clk);
    init_n = 1'b1; rd_cnt = 0;
    repeat (5) cyc();
    chk("t6_no_reads", rd_cnt, 0);
    chk("t6_post_valid", int'(inst_valid), 0);
    chk("t6_post_count", int'(count), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
